// File: rtl/rtype_multicycle_ctrl_if.sv
// Instruction-fetch bus between the R-type sequencer (master) and instruction memory (slave).
// Request is held until memory answers with valid; rdata is sampled only while req is high.
interface rtype_multicycle_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );
endinterface

// File: rtl/rtype_multicycle_ctrl.sv
// Multi-cycle RV32 R-type sequencer: fetch, decode to ALU code, drive regfile addresses and write strobe.
// Latency: 4 cycles per instruction with zero-wait imem (FETCH, DECODE, EXEC, WB); each imem wait cycle adds one.
// Backpressure: imem_req held with a stable address until imem_valid; optional retired counter under RTYPE_PERF_CNT_EN.
module rtype_multicycle_ctrl #(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
`ifdef RTYPE_PERF_CNT_EN
  , parameter int unsigned        CNT_W    = 32
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  rtype_multicycle_ctrl_if.master imem,
  output logic [4:0]              rs1_addr,
  output logic [4:0]              rs2_addr,
  output logic [4:0]              rd_addr,
  output logic [3:0]              alu_control,
  output logic                    regwrite_control,
  output logic                    busy,
  output logic                    halted,
  output logic                    illegal_instr
`ifdef RTYPE_PERF_CNT_EN
  , output logic [CNT_W-1:0]      retired_count
`endif
);

  localparam logic [6:0] OPC_OP   = 7'b0110011;
  localparam logic [6:0] F7_BASE  = 7'd0;
  localparam logic [6:0] F7_ALT   = 7'd32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       ir;
  logic              req_q;

  logic              dec_legal;
  logic [3:0]        dec_alu;

  logic [6:0]        ir_opcode;
  logic [2:0]        ir_func3;
  logic [6:0]        ir_func7;

  assign ir_opcode = ir[6:0];
  assign ir_func3  = ir[14:12];
  assign ir_func7  = ir[31:25];

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = req_q ? pc : '0;

  // Only the ten base R-type encodings are legal; the alt func7 is valid solely for SUB and SRA.
  always_comb begin
    dec_legal = 1'b0;
    dec_alu   = ALU_ADD;
    if (ir_opcode == OPC_OP) begin
      case ({ir_func7, ir_func3})
        {F7_BASE, 3'd0}: begin dec_legal = 1'b1; dec_alu = ALU_ADD;  end
        {F7_ALT,  3'd0}: begin dec_legal = 1'b1; dec_alu = ALU_SUB;  end
        {F7_BASE, 3'd1}: begin dec_legal = 1'b1; dec_alu = ALU_SLL;  end
        {F7_BASE, 3'd2}: begin dec_legal = 1'b1; dec_alu = ALU_SLT;  end
        {F7_BASE, 3'd3}: begin dec_legal = 1'b1; dec_alu = ALU_SLTU; end
        {F7_BASE, 3'd4}: begin dec_legal = 1'b1; dec_alu = ALU_XOR;  end
        {F7_BASE, 3'd5}: begin dec_legal = 1'b1; dec_alu = ALU_SRL;  end
        {F7_ALT,  3'd5}: begin dec_legal = 1'b1; dec_alu = ALU_SRA;  end
        {F7_BASE, 3'd6}: begin dec_legal = 1'b1; dec_alu = ALU_OR;   end
        {F7_BASE, 3'd7}: begin dec_legal = 1'b1; dec_alu = ALU_AND;  end
        default: begin
          dec_legal = 1'b0;
          dec_alu   = ALU_ADD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      pc               <= RESET_PC;
      ir               <= '0;
      req_q            <= 1'b0;
      rs1_addr         <= '0;
      rs2_addr         <= '0;
      rd_addr          <= '0;
      alu_control      <= '0;
      regwrite_control <= 1'b0;
      busy             <= 1'b0;
      halted           <= 1'b0;
      illegal_instr    <= 1'b0;
    end else begin
      regwrite_control <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            req_q <= 1'b1;
            busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem.imem_valid) begin
            ir    <= imem.imem_rdata;
            req_q <= 1'b0;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (dec_legal) begin
            rs1_addr    <= ir[19:15];
            rs2_addr    <= ir[24:20];
            rd_addr     <= ir[11:7];
            alu_control <= dec_alu;
            state       <= S_EXEC;
          end else begin
            state         <= S_HALT;
            busy          <= 1'b0;
            halted        <= 1'b1;
            illegal_instr <= 1'b1;
          end
        end
        S_EXEC: begin
          // Writes to x0 are dropped here so the regfile never sees a strobe for them.
          regwrite_control <= (rd_addr != 5'd0);
          state            <= S_WB;
        end
        S_WB: begin
          pc <= pc + ADDR_W'(4);
          if (stop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= S_FETCH;
            req_q <= 1'b1;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_IDLE;
          req_q <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef RTYPE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_count <= '0;
    end else if (state == S_WB) begin
      retired_count <= retired_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_rtype_multicycle_ctrl.sv
// Scoreboard bench: a program-level model queues expected fetch addresses and register writes; a monitor checks them.
module tb_rtype_multicycle_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic [3:0]  alu_control;
  logic        regwrite_control;
  logic        busy;
  logic        halted;
  logic        illegal_instr;
`ifdef RTYPE_PERF_CNT_EN
  logic [31:0] retired_count;
`endif

  rtype_multicycle_ctrl_if #(.ADDR_W(32)) imem_bus ();

  rtype_multicycle_ctrl #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .stop             (stop),
    .imem             (imem_bus),
    .rs1_addr         (rs1_addr),
    .rs2_addr         (rs2_addr),
    .rd_addr          (rd_addr),
    .alu_control      (alu_control),
    .regwrite_control (regwrite_control),
    .busy             (busy),
    .halted           (halted),
    .illegal_instr    (illegal_instr)
`ifdef RTYPE_PERF_CNT_EN
    , .retired_count  (retired_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total;
  int          bad;
  int          cyc;
  int          fetch_cyc;
  int          hs_n;
  int          fetch_n;
  int          stop_at;
  int          wait_mode;
  int          cur_wait;
  int          model_ret;
  bit          model_halt;
  logic [31:0] model_pc;
  logic [31:0] mem [0:63];
  logic [31:0] fetch_q [$];
  logic [18:0] wr_q [$];
  // Index in this table is the ALU code: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND.
  bit   [9:0]  op_key [0:9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s: got event expected none", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit ref_decode(input logic [31:0] w, output logic [3:0] code);
    code = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (w[6:0] == 7'h33 && {w[31:25], w[14:12]} == op_key[i]) begin
        code = 4'(i);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] rtype_word(input int idx, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2);
    bit [9:0] k;
    k = op_key[idx];
    return {k[9:3], rs2, rs1, k[2:0], rd, 7'h33};
  endfunction

  function automatic logic [31:0] illegal_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 2))
      0:       w[6:0] = 7'h13;
      1:       begin w[6:0] = 7'h33; w[31:25] = 7'h01; end
      default: begin w[6:0] = 7'h33; w[31:25] = 7'h20; w[14:12] = 3'd1; end
    endcase
    return w;
  endfunction

  function automatic int next_wait();
    if (wait_mode == 0) return 0;
    if (wait_mode == 1) return 3;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    fetch_q.delete();
    wr_q.delete();
    model_pc   = 32'h0;
    model_ret  = 0;
    model_halt = 1'b0;
  endtask

  task automatic chk_count();
`ifdef RTYPE_PERF_CNT_EN
    chk("retired_count", retired_count, model_ret);
`endif
  endtask

  // Walks the program from the model PC: at most n instructions, stopping at the first illegal one.
  task automatic run(input int n, input int wmode);
    logic [3:0]  code;
    logic [31:0] w;
    int          guard;
    for (int i = 0; i < n && !model_halt; i++) begin
      w = mem[model_pc[7:2]];
      fetch_q.push_back(model_pc);
      if (!ref_decode(w, code)) begin
        model_halt = 1'b1;
      end else begin
        if (w[11:7] != 5'd0) wr_q.push_back({w[11:7], w[19:15], w[24:20], code});
        model_ret++;
        model_pc = model_pc + 32'd4;
      end
    end
    wait_mode = wmode;
    cur_wait  = next_wait();
    fetch_n   = 0;
    stop_at   = n;
    stop      = 1'b0;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("req_after_start", imem_bus.imem_req, 1);
    guard = 0;
    while (busy && guard < 400) begin
      start = ($urandom_range(0, 3) == 0);
      tick();
      guard++;
    end
    start = 1'b0;
    if (busy) flag("run_timeout");
    chk("halted", halted, model_halt);
    chk("illegal_instr", illegal_instr, model_halt);
    chk("fetch_q_left", fetch_q.size(), 0);
    chk("wr_q_left", wr_q.size(), 0);
    chk_count();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          guard;
    int          seen;
    logic [18:0] e;
    total = 0;
    bad   = 0;
    cyc   = 0;
    hs_n  = 0;
    fetch_cyc = 0;
    op_key = '{{7'd0, 3'd0}, {7'd32, 3'd0}, {7'd0, 3'd1}, {7'd0, 3'd2}, {7'd0, 3'd3},
               {7'd0, 3'd4}, {7'd0, 3'd5}, {7'd32, 3'd5}, {7'd0, 3'd6}, {7'd0, 3'd7}};
    imem_bus.imem_valid = 1'b0;
    imem_bus.imem_rdata = 32'h0;
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    stop_at = 0;
    fetch_n = 0;
    wait_mode = 0;
    cur_wait = 0;
    for (int a = 0; a < 64; a++) mem[a] = 32'h00000013;

    fork
      // Instruction memory: answers a held request after cur_wait cycles, injects stray valids otherwise.
      begin
        int cnt;
        cnt = 0;
        forever begin
          @(posedge clk);
          #1;
          imem_bus.imem_valid = 1'b0;
          if (reset) begin
            cnt = 0;
          end else if (imem_bus.imem_req) begin
            if (cnt >= cur_wait) begin
              imem_bus.imem_valid = 1'b1;
              imem_bus.imem_rdata = mem[imem_bus.imem_addr[7:2]];
              fetch_n++;
              if (fetch_n == stop_at) stop = 1'b1;
              cnt = 0;
              cur_wait = next_wait();
            end else begin
              cnt++;
            end
          end else if ($urandom_range(0, 3) == 0) begin
            imem_bus.imem_valid = 1'b1;
            imem_bus.imem_rdata = $urandom;
          end
        end
      end
      begin
        forever begin
          @(negedge clk);
          cyc++;
          if (!reset) begin
            if (imem_bus.imem_req) begin
              if (fetch_q.size() == 0) begin
                flag("unexpected_fetch");
              end else begin
                chk("imem_addr", imem_bus.imem_addr, fetch_q[0]);
                if (imem_bus.imem_valid) begin
                  void'(fetch_q.pop_front());
                  fetch_cyc = cyc;
                  hs_n++;
                end
              end
            end
            if (regwrite_control) begin
              if (wr_q.size() == 0) begin
                flag("unexpected_regwrite");
              end else begin
                e = wr_q.pop_front();
                chk("wb_rd_rs1_rs2_alu", {rd_addr, rs1_addr, rs2_addr, alu_control}, e);
                chk("wb_latency", cyc - fetch_cyc, 3);
              end
            end
          end
        end
      end
    join_none

    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal_instr, 0);
    chk("rst_regwrite", regwrite_control, 0);
    chk("rst_req", imem_bus.imem_req, 0);
    chk("rst_addr", imem_bus.imem_addr, 0);
    chk("rst_regs", {rs1_addr, rs2_addr, rd_addr, alu_control}, 0);
    chk_count();

    mem[0] = 32'h002081B3;
    mem[1] = 32'h402081B3;
    mem[2] = 32'h4020D1B3;
    mem[3] = 32'h00208033;
    mem[4] = 32'h00000013;
    run(1, 0);
    run(2, 0);
    run(1, 1);
    run(2, 2);

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("halt_sticky", halted, 1);
    chk("halt_busy", busy, 0);
    chk("halt_illegal", illegal_instr, 1);

    do_reset();
    chk("rerst_halted", halted, 0);
    chk("rerst_illegal", illegal_instr, 0);
    run(1, 0);

    // Abort the instruction at PC 4 while it sits in EXEC.
    fetch_q.push_back(32'h4);
    wait_mode = 0;
    cur_wait  = 0;
    fetch_n   = 0;
    stop_at   = 99;
    stop      = 1'b0;
    seen      = hs_n;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    guard     = 0;
    while (hs_n == seen && guard < 50) begin
      tick();
      guard++;
    end
    if (hs_n == seen) flag("abort_fetch_timeout");
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_req", imem_bus.imem_req, 0);
    chk("abort_regwrite", regwrite_control, 0);
    chk("abort_regs", {rs1_addr, rs2_addr, rd_addr, alu_control}, 0);
    fetch_q.delete();
    wr_q.delete();
    model_pc   = 32'h0;
    model_ret  = 0;
    model_halt = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk_count();
    run(1, 0);

    for (int it = 0; it < 6; it++) begin
      do_reset();
      for (int a = 0; a < 64; a++) begin
        mem[a] = rtype_word(int'($urandom_range(0, 9)),
                            ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end
      if (it % 2 == 1) mem[$urandom_range(2, 20)] = illegal_word();
      for (int r = 0; r < 5 && !model_halt; r++) run(int'($urandom_range(1, 6)), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
